// File: rtl/line_memory.sv
// line_memory: line-granular backing store below the data cache.
// One request at a time; each completes a fixed DELAY cycles after accept.
// A read completion returns one full line with a single-cycle valid pulse.
module line_memory #(
   parameter int unsigned BLOCK_SIZE = 16,
   parameter int unsigned NUM_LINES  = 256,
   parameter int unsigned DELAY      = 50
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      is_input_valid,
   input  logic [31:0]               addr,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [BLOCK_SIZE*8-1:0]   din,
   output logic                      is_output_valid,
   output logic [BLOCK_SIZE*8-1:0]   dout,
   output logic                      mem_ready
);

   localparam int unsigned LINE_W = BLOCK_SIZE * 8;
   localparam int unsigned OFF    = $clog2(BLOCK_SIZE);
   localparam int unsigned IDX    = $clog2(NUM_LINES);
   localparam int unsigned CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_accept;
   logic                w_complete;
   logic [IDX-1:0]      w_idx;
   logic                w_unused_addr;

   logic [CNT_W-1:0]    r_count;
   logic [IDX-1:0]      r_idx;
   logic                r_is_read;
   logic [LINE_W-1:0]   r_wdata;
   logic [LINE_W-1:0]   r_mem [NUM_LINES];

   logic                r_out_valid;
   logic [LINE_W-1:0]   r_dout;
   logic                r_ready;

   // Line index from the address; offset and upper bits alias onto the same line
   assign w_idx         = addr[OFF+IDX-1:OFF];
   assign w_unused_addr = ^{addr[31:OFF+IDX], addr[OFF-1:0]};

   // Next-state decode: accept a well-formed request in IDLE, finish when the counter drains
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (is_input_valid && (mem_read ^ mem_write)) begin
               w_accept     = 1'b1;
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_count == '0) begin
               w_complete   = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Latch the accepted request and run the latency counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= '0;
         r_idx     <= '0;
         r_is_read <= 1'b0;
         r_wdata   <= '0;
      end else if (w_accept) begin
         r_count   <= CNT_LOAD;
         r_idx     <= w_idx;
         r_is_read <= mem_read;
         r_wdata   <= din;
      end else if ((r_state == ST_BUSY) && (r_count != '0)) begin
         r_count   <= r_count - CNT_W'(1);
      end
   end

   // Line storage; a write commits only at its completion edge
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_LINES; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_complete && !r_is_read) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   // Registered outputs: read data with one-cycle valid pulse, ready from next state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_ready     <= 1'b1;
      end else begin
         r_out_valid <= w_complete && r_is_read;
         if (w_complete && r_is_read) begin
            r_dout <= r_mem[r_idx];
         end
         r_ready <= (w_next_state == ST_IDLE);
      end
   end

   assign is_output_valid = r_out_valid;
   assign dout            = r_dout;
   assign mem_ready       = r_ready;

endmodule
